// File: rtl/enc_emu_pkg.sv
// Shared types and helpers for the motor/quadrature encoder emulator.
// Quadrature state values are chosen so the state bits are {A,B} directly.
package enc_emu_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } quad_state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // One quadrature step; forward walks S0->S1->S2->S3, reverse walks back.
  function automatic quad_state_e next_state(input quad_state_e state, input logic dir);
    quad_state_e nxt;
    nxt = state;
    case (state)
      S0: nxt = (dir == DIR_FWD) ? S1 : S3;
      S1: nxt = (dir == DIR_FWD) ? S2 : S0;
      S2: nxt = (dir == DIR_FWD) ? S3 : S1;
      S3: nxt = (dir == DIR_FWD) ? S0 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_duty_meter.sv
// Measures enable duty over a fixed power-of-two window and latches it as speed,
// applying a static-friction deadband.
module pwm_duty_meter #(
  parameter int unsigned PWM_WINDOW = 4096,
  parameter int unsigned MIN_COUNT  = 410,
  parameter int unsigned SPD_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_en,
  output logic [SPD_W-1:0] speed
);

  localparam int unsigned WIN_W = $clog2(PWM_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PWM_WINDOW - 1);
  localparam logic [SPD_W-1:0] MIN_CNT  = SPD_W'(MIN_COUNT);

  logic [WIN_W-1:0] win_cnt;
  logic [SPD_W-1:0] duty_cnt;
  logic [SPD_W-1:0] duty_sum;

  // Include the current cycle so a full window of enable reads PWM_WINDOW.
  assign duty_sum = duty_cnt + SPD_W'(motor_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt  <= '0;
      duty_cnt <= '0;
      speed    <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      if (win_cnt == WIN_LAST) begin
        duty_cnt <= '0;
        speed    <= (duty_sum < MIN_CNT) ? '0 : duty_sum;
      end else begin
        duty_cnt <= duty_sum;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// DC motor + quadrature encoder emulator: PWM duty sets a phase-accumulator
// rate, each accumulator carry advances the A/B quadrature state one step.
module quad_encoder_emulator
  import enc_emu_pkg::*;
#(
  parameter int unsigned PWM_WINDOW = 4096,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned MIN_COUNT  = 410,
  parameter int unsigned SPD_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_dir,
  input  logic             motor_en,
  output logic             enc_a,
  output logic             enc_b,
  output logic             edge_strobe,
  output logic [31:0]      position,
  output logic [SPD_W-1:0] speed
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             step;

  quad_state_e state_q;
  quad_state_e state_d;
  logic        strobe_d;
  logic [31:0] pos_d;

  pwm_duty_meter #(
    .PWM_WINDOW (PWM_WINDOW),
    .MIN_COUNT  (MIN_COUNT),
    .SPD_W      (SPD_W)
  ) u_duty (
    .clk      (clk),
    .reset    (reset),
    .motor_en (motor_en),
    .speed    (speed)
  );

  // Carry out of the accumulator is the step event; uses the speed already latched.
  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(speed);
  assign step    = acc_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[ACC_W-1:0];
    end
  end

  // Quadrature state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: direction is only looked at on a step.
  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = next_state(state_q, motor_dir);
    end
  end

  // Output decode for strobe and position, registered below.
  always_comb begin
    strobe_d = 1'b0;
    pos_d    = position;
    if (step) begin
      strobe_d = 1'b1;
      pos_d    = (motor_dir == DIR_FWD) ? position + 32'd1 : position - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_strobe <= 1'b0;
      position    <= '0;
    end else begin
      edge_strobe <= strobe_d;
      position    <= pos_d;
    end
  end

  assign {enc_a, enc_b} = state_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator with a legal-transition monitor on A/B.
`timescale 1ns/1ps
module tb_quad_encoder_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        motor_dir = 1'b1;
  logic        motor_en = 1'b0;
  logic        enc_a, enc_b, edge_strobe;
  logic [31:0] position;
  logic [12:0] speed;

  int n_cmp  = 0;
  int n_fail = 0;

  quad_encoder_emulator dut (
    .clk         (clk),
    .reset       (reset),
    .motor_dir   (motor_dir),
    .motor_en    (motor_en),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .edge_strobe (edge_strobe),
    .position    (position),
    .speed       (speed)
  );

  always #5 clk = ~clk;

  // Legal-transition monitor: a strobe must move one quadrature step, otherwise A/B hold.
  logic       rst_q = 1'b1;
  logic [1:0] prev_ab = 2'b00;
  always @(posedge clk) rst_q <= reset;

  function automatic logic [1:0] fwd_of(input logic [1:0] ab);
    case (ab)
      2'b00: return 2'b10;
      2'b10: return 2'b11;
      2'b11: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] ab);
    case (ab)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_q) begin
      if (edge_strobe) begin
        n_cmp++;
        if ({enc_a, enc_b} !== fwd_of(prev_ab) && {enc_a, enc_b} !== rev_of(prev_ab)) begin
          n_fail++;
          $display("FAIL ab_step: got %b from %b, required a neighbour state", {enc_a, enc_b}, prev_ab);
        end
      end else if ({enc_a, enc_b} !== prev_ab) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ab_hold: got %b without strobe, required %b", {enc_a, enc_b}, prev_ab);
      end
    end
    prev_ab = {enc_a, enc_b};
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    motor_en = 1'b0;
    motor_dir = 1'b1;
    step_clk();
    step_clk();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int strobes = 0;
    do_reset();
    n_cmp++;
    if ({enc_a, enc_b, edge_strobe} !== 3'b000 || position !== 32'd0 || speed !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_vals: got ab=%b strobe=%b pos=%0d speed=%0d, required all 0",
               {enc_a, enc_b}, edge_strobe, position, speed);
    end
    for (int n = 1; n <= 3 * 4096; n++) begin
      step_clk();
      if (edge_strobe) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL idle_strobes: got %0d, required 0", strobes);
    end
    n_cmp++;
    if (speed !== 13'd0) begin
      n_fail++;
      $display("FAIL idle_speed: got %0d, required 0", speed);
    end
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b00 || position !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_ab_pos: got ab=%b pos=%0d, required ab=00 pos=0", {enc_a, enc_b}, position);
    end
  endtask

  // Full duty forward; after four edges, direction flips for one step then flips back.
  task automatic test_full_fwd();
    logic [1:0] exp_ab [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00};
    int         exp_pos[6] = '{1, 2, 3, 4, 3, 4};
    int k = 0;
    do_reset();
    motor_en = 1'b1;
    for (int n = 1; n <= 28672; n++) begin
      if (n == 20481) motor_dir = 1'b0;
      if (n == 24577) motor_dir = 1'b1;
      step_clk();
      if (n == 4095) begin
        n_cmp++;
        if (speed !== 13'd0) begin
          n_fail++;
          $display("FAIL fwd_speed_pre: clk %0d got %0d, required 0", n, speed);
        end
      end
      if (n == 4096) begin
        n_cmp++;
        if (speed !== 13'd4096) begin
          n_fail++;
          $display("FAIL fwd_speed: got %0d, required 4096", speed);
        end
      end
      if (edge_strobe) begin
        n_cmp++;
        if (k >= 6 || n != 8192 + 4096 * k) begin
          n_fail++;
          $display("FAIL fwd_edge_time: edge %0d at clk %0d, required clk %0d", k, n, 8192 + 4096 * k);
        end else if ({enc_a, enc_b} !== exp_ab[k] || position !== 32'(exp_pos[k])) begin
          n_fail++;
          $display("FAIL fwd_edge_val: edge %0d got ab=%b pos=%0d, required ab=%b pos=%0d",
                   k, {enc_a, enc_b}, $signed(position), exp_ab[k], exp_pos[k]);
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL fwd_edge_count: got %0d, required 6", k);
    end
  endtask

  // Single-cycle reset at full speed, then the start-up sequence must repeat exactly.
  task automatic test_back_to_back();
    int strobes = 0;
    motor_en = 1'b1;
    motor_dir = 1'b1;
    for (int n = 0; n < 1000; n++) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    n_cmp++;
    if ({enc_a, enc_b, edge_strobe} !== 3'b000 || position !== 32'd0 || speed !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_vals: got ab=%b strobe=%b pos=%0d speed=%0d, required all 0",
               {enc_a, enc_b}, edge_strobe, position, speed);
    end
    for (int n = 1; n <= 8192; n++) begin
      step_clk();
      if (n == 4096) begin
        n_cmp++;
        if (speed !== 13'd4096) begin
          n_fail++;
          $display("FAIL midrst_speed: got %0d, required 4096", speed);
        end
      end
      if (n < 8192 && edge_strobe) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL midrst_early: got %0d early strobes, required 0", strobes);
    end
    n_cmp++;
    if (edge_strobe !== 1'b1 || {enc_a, enc_b} !== 2'b10 || position !== 32'd1) begin
      n_fail++;
      $display("FAIL midrst_first: got strobe=%b ab=%b pos=%0d, required 1 10 1",
               edge_strobe, {enc_a, enc_b}, position);
    end
  endtask

  task automatic test_half_rev();
    logic [1:0]  exp_ab [2] = '{2'b01, 2'b11};
    logic [31:0] exp_pos[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int k = 0;
    do_reset();
    motor_dir = 1'b0;
    for (int n = 1; n <= 20480; n++) begin
      motor_en = (((n - 1) % 4) < 2);
      step_clk();
      if (n == 4096) begin
        n_cmp++;
        if (speed !== 13'd2048) begin
          n_fail++;
          $display("FAIL half_speed: got %0d, required 2048", speed);
        end
      end
      if (edge_strobe) begin
        n_cmp++;
        if (k >= 2 || n != 12288 + 8192 * k) begin
          n_fail++;
          $display("FAIL half_edge_time: edge %0d at clk %0d, required clk %0d", k, n, 12288 + 8192 * k);
        end else if ({enc_a, enc_b} !== exp_ab[k] || position !== exp_pos[k]) begin
          n_fail++;
          $display("FAIL half_edge_val: edge %0d got ab=%b pos=%h, required ab=%b pos=%h",
                   k, {enc_a, enc_b}, position, exp_ab[k], exp_pos[k]);
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL half_edge_count: got %0d, required 2", k);
    end
  endtask

  task automatic test_deadband();
    int strobes = 0;
    do_reset();
    motor_dir = 1'b1;
    for (int n = 1; n <= 8192; n++) begin
      motor_en = (n <= 400) || (n > 4096 && n <= 4506);
      step_clk();
      if (edge_strobe) strobes++;
      if (n == 4096) begin
        n_cmp++;
        if (speed !== 13'd0) begin
          n_fail++;
          $display("FAIL dead_400: got %0d, required 0", speed);
        end
      end
      if (n == 8192) begin
        n_cmp++;
        if (speed !== 13'd410) begin
          n_fail++;
          $display("FAIL dead_410: got %0d, required 410", speed);
        end
      end
    end
    n_cmp++;
    if (strobes !== 0 || {enc_a, enc_b} !== 2'b00 || position !== 32'd0) begin
      n_fail++;
      $display("FAIL dead_frozen: got strobes=%0d ab=%b pos=%0d, required 0 00 0",
               strobes, {enc_a, enc_b}, position);
    end
  endtask

  initial begin
    test_reset();
    test_full_fwd();
    test_back_to_back();
    test_half_rev();
    test_deadband();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
